ascon_share_unmasker: RTL and testbench
=======================================

Name: ascon_share_unmasker

Overview:
- Output-side counterpart to the share-generation path of the masked Ascon core.
- Receives the NUM_SHARES Boolean shares of each 64-bit state/output word, one share per beat.
- XOR-recombines the shares into the unmasked word and presents it on a valid/ready output port.
- Sits between the masked permutation datapath and the unmasked tag/ciphertext output interface.

Parameters:
NUM_SHARES, 11, number of Boolean shares per word (d+1 with d=10); legal range 1..64.
WORD_SIZE, 64, width of one share and of the recombined word.
CNT_W, $clog2(NUM_SHARES+1), share counter width (derived, not overridden).

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous, active-high reset
in_share_i  input  WORD_SIZE  one share of the current word
in_valid_i  input  1  in_share_i valid
in_last_i  input  1  sender marks final share of a word
in_ready_o  output  1  unmasker accepts a share this cycle
out_word_o  output  WORD_SIZE  recombined (unmasked) word
out_valid_o  output  1  out_word_o valid
out_ready_i  input  1  downstream accepts out_word_o
share_err_o  output  1  share-count mismatch flag (see Optional Feature)

Behaviour:
- Reset (rst_i=1 at a clk_i edge): acc=0, share_cnt=0, state=COLLECT, out_word_o=0, out_valid_o=0, share_err_o=0. Reset overrides everything, including a word in progress or a held output; any partial accumulation is discarded.
- Input beat = in_valid_i & in_ready_o. Output beat = out_valid_o & out_ready_i.
- States:
  - COLLECT: in_ready_o=1, out_valid_o=0.
  - HOLD: out_valid_o=1, in_ready_o=out_ready_i.
- Accumulation on an input beat:
  - next = (share_cnt==0 ? in_share_i : acc ^ in_share_i).
  - If share_cnt < NUM_SHARES-1: acc<=next, share_cnt++.
  - If share_cnt == NUM_SHARES-1 (final share): out_word_o<=next, out_valid_o<=1, share_cnt<=0, acc<=0, state->HOLD.
- HOLD behaviour:
  - Output beat with no completing input beat: out_valid_o<=0, state->COLLECT. out_word_o retains its last value.
  - Output beat and input beat in the same cycle: the input beat is processed as above. If it completes a word (only possible when NUM_SHARES=1), out_word_o is reloaded and out_valid_o stays 1.
  - No output beat: in_ready_o=0, and out_word_o is held stable.
- Latency: out_valid_o rises the cycle after the final share is accepted.
- Throughput: 1 word per NUM_SHARES cycles with out_ready_i tied high. No bubble between words.
- Datapath is pure bitwise XOR; no carries and no width growth.
- in_valid_i low: no state change. in_share_i is don't-care when in_valid_i=0.
- out_word_o is never driven by a partial XOR, so no share or partial sum is ever exposed.

Optional Feature:
- Macro: ASCON_UNMASK_SHARE_CHECK_EN.
- Defined:
  - On every input beat, compare in_last_i with (share_cnt==NUM_SHARES-1).
  - On mismatch, set share_err_o<=1 (sticky until rst_i), drop the word (acc<=0, share_cnt<=0, no output produced) and stay in COLLECT.
  - The next accepted beat is treated as share 0.
- Not defined:
  - in_last_i is ignored and share_err_o is tied to 0.
  - Word boundaries are set by share_cnt alone.

Test Plan:
- NUM_SHARES=3, out_ready_i=1; shares 0x0123456789ABCDEF, 0xFFFF0000FFFF0000, 0x1111111111111111 on consecutive cycles, in_last_i on the third -> out_valid_o=1 exactly one cycle after the third share, out_word_o=0xEFCD54766745DCFE, then out_valid_o=0.
- NUM_SHARES=11; 11 shares all 0xA5A5A5A5A5A5A5A5 -> out_word_o=0xA5A5A5A5A5A5A5A5 (odd count); repeat with 10 equal shares plus one 0 share -> out_word_o=0.
- Backpressure: out_ready_i=0 after a completed word -> in_ready_o=0, and out_word_o/out_valid_o are stable for 5 cycles. Raise out_ready_i -> word consumed; next word's first share is accepted in that same cycle.
- Reset mid-word: NUM_SHARES=3, accept 2 shares, assert rst_i for one cycle, then send 3 fresh shares -> output equals the XOR of the fresh shares only; all outputs were 0 the cycle after reset.
- NUM_SHARES=1 with continuous valid and out_ready_i=1 -> one word per cycle, out_valid_o held high, each out_word_o equals the share from the previous cycle.
- With ASCON_UNMASK_SHARE_CHECK_EN, NUM_SHARES=3: in_last_i asserted on share 2 -> share_err_o=1 next cycle and stays 1, no output produced, and the following 3-share word recombines correctly. Without the macro, the same stimulus -> share_err_o=0 and the word completes after the third share.

Source files
------------

// File: rtl/ascon_share_unmasker.sv
`default_nettype none
// ============================================================================
// Module  : ascon_share_unmasker
// Brief   : XOR-recombines NUM_SHARES Boolean shares (one per beat) into an
//           unmasked word on a valid/ready port. Optional in_last_i checking
//           is enabled by ASCON_UNMASK_SHARE_CHECK_EN.
// Revision: 1.0 - initial release
// ============================================================================
module ascon_share_unmasker #(
   parameter int NUM_SHARES = 11,
   parameter int WORD_SIZE  = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [WORD_SIZE-1:0] in_share_i,
   input  logic                 in_valid_i,
   input  logic                 in_last_i,
   output logic                 in_ready_o,
   output logic [WORD_SIZE-1:0] out_word_o,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic                 share_err_o
);

   localparam int CNT_W = $clog2(NUM_SHARES + 1);

   localparam logic [0:0]       c_COLLECT = 1'b0;
   localparam logic [0:0]       c_HOLD    = 1'b1;
   localparam logic [CNT_W-1:0] c_LAST    = CNT_W'(NUM_SHARES - 1);
   localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

   logic [0:0]           r_state;
   logic [CNT_W-1:0]     r_share_cnt;
   logic [WORD_SIZE-1:0] r_acc;
   logic [WORD_SIZE-1:0] r_out_word;

   logic                 w_in_beat;
   logic                 w_out_beat;
   logic                 w_final;
   logic                 w_mismatch;
   logic [WORD_SIZE-1:0] w_next;

   assign out_valid_o = (r_state == c_HOLD);
   assign in_ready_o  = (r_state == c_COLLECT) | out_ready_i;
   assign out_word_o  = r_out_word;

   assign w_in_beat  = in_valid_i & in_ready_o;
   assign w_out_beat = out_valid_o & out_ready_i;
   assign w_final    = (r_share_cnt == c_LAST);
   assign w_next     = (r_share_cnt == '0) ? in_share_i : (r_acc ^ in_share_i);

`ifdef ASCON_UNMASK_SHARE_CHECK_EN
   logic r_share_err;

   assign w_mismatch  = (in_last_i != w_final);
   assign share_err_o = r_share_err;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_share_err <= 1'b0;
      end else if (w_in_beat && w_mismatch) begin
         r_share_err <= 1'b1;
      end
   end
`else
   logic w_unused_last;

   assign w_unused_last = in_last_i;
   assign w_mismatch    = 1'b0;
   assign share_err_o   = 1'b0;
`endif

   // A completing input beat below overrides the return to COLLECT, so a
   // simultaneous consume-and-complete keeps out_valid_o high.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= c_COLLECT;
         r_share_cnt <= '0;
         r_acc       <= '0;
         r_out_word  <= '0;
      end else begin
         if (w_out_beat) begin
            r_state <= c_COLLECT;
         end
         if (w_in_beat) begin
            if (w_mismatch) begin
               r_acc       <= '0;
               r_share_cnt <= '0;
            end else if (w_final) begin
               r_out_word  <= w_next;
               r_state     <= c_HOLD;
               r_acc       <= '0;
               r_share_cnt <= '0;
            end else begin
               r_acc       <= w_next;
               r_share_cnt <= r_share_cnt + c_ONE;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ascon_share_unmasker.sv
`default_nettype none
// ============================================================================
// Module  : tb_ascon_share_unmasker
// Brief   : Directed bench for ascon_share_unmasker at 3, 11 and 1 shares.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ascon_share_unmasker;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // NUM_SHARES = 3
   logic [63:0] s3_share = '0;
   logic        s3_valid = 1'b0, s3_last = 1'b0, s3_oready = 1'b1;
   logic        s3_ready, s3_ovalid, s3_err;
   logic [63:0] s3_word;
   // NUM_SHARES = 11
   logic [63:0] s11_share = '0;
   logic        s11_valid = 1'b0, s11_last = 1'b0, s11_oready = 1'b1;
   logic        s11_ready, s11_ovalid, s11_err;
   logic [63:0] s11_word;
   // NUM_SHARES = 1
   logic [63:0] s1_share = '0;
   logic        s1_valid = 1'b0, s1_last = 1'b1, s1_oready = 1'b1;
   logic        s1_ready, s1_ovalid, s1_err;
   logic [63:0] s1_word;

   ascon_share_unmasker #(.NUM_SHARES(3), .WORD_SIZE(64)) u_dut3 (
      .clk_i(clk), .rst_i(rst), .in_share_i(s3_share), .in_valid_i(s3_valid),
      .in_last_i(s3_last), .in_ready_o(s3_ready), .out_word_o(s3_word),
      .out_valid_o(s3_ovalid), .out_ready_i(s3_oready), .share_err_o(s3_err));

   ascon_share_unmasker #(.NUM_SHARES(11), .WORD_SIZE(64)) u_dut11 (
      .clk_i(clk), .rst_i(rst), .in_share_i(s11_share), .in_valid_i(s11_valid),
      .in_last_i(s11_last), .in_ready_o(s11_ready), .out_word_o(s11_word),
      .out_valid_o(s11_ovalid), .out_ready_i(s11_oready), .share_err_o(s11_err));

   ascon_share_unmasker #(.NUM_SHARES(1), .WORD_SIZE(64)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .in_share_i(s1_share), .in_valid_i(s1_valid),
      .in_last_i(s1_last), .in_ready_o(s1_ready), .out_word_o(s1_word),
      .out_valid_o(s1_ovalid), .out_ready_i(s1_oready), .share_err_o(s1_err));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%016h expected=0x%016h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send3(input logic [63:0] s, input logic last);
      s3_share = s;
      s3_valid = 1'b1;
      s3_last  = last;
      tick();
      s3_valid = 1'b0;
      s3_last  = 1'b0;
   endtask

   initial begin
      tick();
      tick();
      rst = 1'b0;
      check("rst_word",  s3_word, 64'h0);
      check("rst_valid", {63'b0, s3_ovalid}, 64'h0);
      check("rst_err",   {63'b0, s3_err}, 64'h0);
      check("rst_ready", {63'b0, s3_ready}, 64'h1);

      // Basic three-share recombination with one-cycle latency
      send3(64'h0123456789ABCDEF, 1'b0);
      send3(64'hFFFF0000FFFF0000, 1'b0);
      check("t1_valid_before", {63'b0, s3_ovalid}, 64'h0);
      send3(64'h1111111111111111, 1'b1);
      check("t1_valid", {63'b0, s3_ovalid}, 64'h1);
      check("t1_word",  s3_word, 64'hEFCD54766745DCFE);
      tick();
      check("t1_valid_drop", {63'b0, s3_ovalid}, 64'h0);
      check("t1_word_keep",  s3_word, 64'hEFCD54766745DCFE);

      // Backpressure: held output, then consume with same-cycle next share
      s3_oready = 1'b0;
      send3(64'h1, 1'b0);
      send3(64'h2, 1'b0);
      send3(64'h4, 1'b1);
      s3_share = 64'h10;
      s3_valid = 1'b1;
      s3_last  = 1'b0;
      check("bp_ready_low", {63'b0, s3_ready}, 64'h0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_hold_valid", {63'b0, s3_ovalid}, 64'h1);
         check("bp_hold_word",  s3_word, 64'h7);
         check("bp_hold_ready", {63'b0, s3_ready}, 64'h0);
      end
      s3_oready = 1'b1;
      #1;
      check("bp_ready_release", {63'b0, s3_ready}, 64'h1);
      tick();
      s3_valid = 1'b0;
      check("bp_consumed", {63'b0, s3_ovalid}, 64'h0);
      send3(64'h20, 1'b0);
      send3(64'h40, 1'b1);
      check("bp_next_valid", {63'b0, s3_ovalid}, 64'h1);
      check("bp_next_word",  s3_word, 64'h70);
      tick();

      // Reset in the middle of a word discards the partial sum
      send3(64'hDEADDEADDEADDEAD, 1'b0);
      send3(64'hBEEFBEEFBEEFBEEF, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mr_word",  s3_word, 64'h0);
      check("mr_valid", {63'b0, s3_ovalid}, 64'h0);
      check("mr_err",   {63'b0, s3_err}, 64'h0);
      check("mr_ready", {63'b0, s3_ready}, 64'h1);
      send3(64'h0F0F0F0F0F0F0F0F, 1'b0);
      send3(64'h00FF00FF00FF00FF, 1'b0);
      send3(64'h3333333333333333, 1'b1);
      check("mr_fresh_valid", {63'b0, s3_ovalid}, 64'h1);
      check("mr_fresh_word",  s3_word, 64'h3CC33CC33CC33CC3);
      tick();

      // Eleven shares: odd count of equal shares, then ten equal plus a zero
      for (int i = 0; i < 11; i++) begin
         s11_share = 64'hA5A5A5A5A5A5A5A5;
         s11_valid = 1'b1;
         s11_last  = (i == 10);
         tick();
         if (i == 9) check("n11_valid_early", {63'b0, s11_ovalid}, 64'h0);
      end
      s11_valid = 1'b0;
      s11_last  = 1'b0;
      check("n11_valid", {63'b0, s11_ovalid}, 64'h1);
      check("n11_word",  s11_word, 64'hA5A5A5A5A5A5A5A5);
      tick();
      for (int i = 0; i < 11; i++) begin
         s11_share = (i == 4) ? 64'h0 : 64'hA5A5A5A5A5A5A5A5;
         s11_valid = 1'b1;
         s11_last  = (i == 10);
         tick();
      end
      s11_valid = 1'b0;
      s11_last  = 1'b0;
      check("n11_zero_valid", {63'b0, s11_ovalid}, 64'h1);
      check("n11_zero_word",  s11_word, 64'h0);
      tick();

      // Single share: one word per cycle, valid never drops
      s1_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         logic [63:0] v;
         v = 64'h0101010101010101 * (i + 3) + 64'h5;
         s1_share = v;
         tick();
         check("n1_valid", {63'b0, s1_ovalid}, 64'h1);
         check("n1_word",  s1_word, v);
         check("n1_ready", {63'b0, s1_ready}, 64'h1);
      end
      s1_valid = 1'b0;
      tick();
      check("n1_valid_drop", {63'b0, s1_ovalid}, 64'h0);

      // Early in_last_i on the second share
      send3(64'hAAAA000000000000, 1'b0);
      send3(64'h0000BBBB00000000, 1'b1);
`ifdef ASCON_UNMASK_SHARE_CHECK_EN
      check("chk_err",     {63'b0, s3_err}, 64'h1);
      check("chk_nooutput", {63'b0, s3_ovalid}, 64'h0);
      send3(64'h000000000000CCCC, 1'b0);
      check("chk_nooutput2", {63'b0, s3_ovalid}, 64'h0);
      send3(64'h00000000DDDD0000, 1'b0);
      send3(64'h1000000000000001, 1'b1);
      check("chk_valid", {63'b0, s3_ovalid}, 64'h1);
      check("chk_word",  s3_word, 64'h10000000DDDDCCCD);
      check("chk_err_sticky", {63'b0, s3_err}, 64'h1);
`else
      check("nochk_err",   {63'b0, s3_err}, 64'h0);
      check("nochk_early", {63'b0, s3_ovalid}, 64'h0);
      send3(64'h000000000000CCCC, 1'b1);
      check("nochk_valid", {63'b0, s3_ovalid}, 64'h1);
      check("nochk_word",  s3_word, 64'hAAAABBBB0000CCCC);
      check("nochk_err2",  {63'b0, s3_err}, 64'h0);
`endif
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
